// File: rtl/toggle_chk_pkg.sv
// Shared definitions for the toggle checker: FSM state encodings, the
// error-counter width and its saturation limit, and a saturating increment.
package toggle_chk_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_ACQUIRE = 2'd2;
  localparam logic [1:0] ST_LOCK    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARM     = ST_ARM,
    ACQUIRE = ST_ACQUIRE,
    LOCK    = ST_LOCK
  } state_t;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Error counter increment that sticks at ERR_CNT_MAX instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/edge_interval_counter.sv
// Edge detector and interval classifier for the toggle checker.
// Registers Q_IN, flags edges combinationally, counts CK cycles since the last
// edge (saturating) and classifies the interval against EXP_HALF +/- TOL.
// Ports:
//   CK       in   clock, rising edge
//   RB       in   asynchronous active-high reset
//   Q_IN     in   monitored signal (same clock domain)
//   is_edge  out  Q_IN differs from its value last cycle
//   good     out  edge with interval inside the tolerance window
//   bad      out  early edge, or non-edge cycle reaching the window limit
//   interval out  cycles elapsed since the previous edge
module edge_interval_counter #(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = 1,
  parameter int TOL      = 0
) (
  input  logic             CK,
  input  logic             RB,
  input  logic             Q_IN,
  output logic             is_edge,
  output logic             good,
  output logic             bad,
  output logic [CNT_W-1:0] interval
);

  localparam logic [CNT_W-1:0] LO      = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HI      = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             q_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CK or posedge RB) begin
    if (RB) begin
      q_d <= 1'b0;
      cnt <= '0;
    end else begin
      q_d <= Q_IN;
      if (is_edge)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign is_edge  = Q_IN ^ q_d;
  assign good     = is_edge && (cnt >= LO) && (cnt <= HI);
  // HI < CNT_MAX, so cnt passes HI exactly once per interval: the timeout
  // fires a single time and cannot recur until an edge restarts cnt.
  // An edge arriving after HI is late but not reported again.
  assign bad      = is_edge ? (cnt < LO) : (cnt == HI);
  assign interval = cnt;

endmodule

// File: rtl/toggle_checker.sv
// Receive-side monitor for a toggle flip-flop output or any square wave on CK.
// Tracks edge-to-edge intervals, locks after LOCK_N consecutive good intervals
// and reports errors seen while locked.
// Ports:
//   CK        in   clock, rising edge
//   RB        in   asynchronous active-high reset
//   EN        in   synchronous enable; low forces IDLE
//   CLR       in   synchronous clear of ERR, ERR_CNT, TOG_CNT
//   Q_IN      in   monitored signal
//   LOCKED    out  interval tracking locked
//   ERR       out  sticky error flag
//   ERR_PULSE out  one-cycle pulse per error while locked
//   ERR_CNT   out  saturating error count
//   TOG_CNT   out  wrapping count of edges seen in ACQUIRE/LOCK
//   LAST_HALF out  most recent measured interval
module toggle_checker
  import toggle_chk_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = 1,
  parameter int TOL      = 0,
  parameter int LOCK_N   = 4,
  parameter int TOG_W    = 16
) (
  input  logic                 CK,
  input  logic                 RB,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic                 Q_IN,
  output logic                 LOCKED,
  output logic                 ERR,
  output logic                 ERR_PULSE,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [TOG_W-1:0]     TOG_CNT,
  output logic [CNT_W-1:0]     LAST_HALF
);

  localparam int                GOOD_W    = $clog2(LOCK_N + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);

  state_t             state;
  logic [GOOD_W-1:0]  good_cnt;
  logic               is_edge;
  logic               good;
  logic               bad;
  logic [CNT_W-1:0]   interval;
  logic               tracking;

  edge_interval_counter #(
    .CNT_W    (CNT_W),
    .EXP_HALF (EXP_HALF),
    .TOL      (TOL)
  ) u_eic (
    .CK       (CK),
    .RB       (RB),
    .Q_IN     (Q_IN),
    .is_edge  (is_edge),
    .good     (good),
    .bad      (bad),
    .interval (interval)
  );

  // Edges are only counted and measured once the ARM edge has been consumed.
  assign tracking = EN && ((state == ACQUIRE) || (state == LOCK));

  always_ff @(posedge CK or posedge RB) begin
    if (RB) begin
      state     <= IDLE;
      good_cnt  <= '0;
      LOCKED    <= 1'b0;
      ERR       <= 1'b0;
      ERR_PULSE <= 1'b0;
      ERR_CNT   <= '0;
      TOG_CNT   <= '0;
      LAST_HALF <= '0;
    end else begin
      ERR_PULSE <= 1'b0;

      if (tracking && is_edge) begin
        TOG_CNT   <= TOG_CNT + TOG_W'(1);
        LAST_HALF <= interval;
      end

      if (!EN) begin
        state    <= IDLE;
        good_cnt <= '0;
        LOCKED   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= ARM;
          ARM:  if (is_edge) state <= ACQUIRE;
          ACQUIRE: begin
            if (good) begin
              if (good_cnt == GOOD_LAST) begin
                state    <= LOCK;
                LOCKED   <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end else if (bad) begin
              good_cnt <= '0;
            end
          end
          LOCK: begin
            if (bad) begin
              ERR_PULSE <= 1'b1;
              ERR       <= 1'b1;
              ERR_CNT   <= sat_inc_err(ERR_CNT);
              LOCKED    <= 1'b0;
              good_cnt  <= '0;
              state     <= ACQUIRE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // NOTE: the last non-blocking assignment in a block wins, so placing the
      // clear after the updates gives CLR priority over same-cycle increments.
      if (CLR) begin
        ERR     <= 1'b0;
        ERR_CNT <= '0;
        TOG_CNT <= '0;
      end
    end
  end

endmodule

// File: doc/toggle_checker.md
Name: toggle_checker

Overview:
- Receive-side monitor for the toggle flip-flop output (the divide-by-2 `flipflop_not` Q, or any square wave generated on the same clock).
- Samples Q_IN on CK, detects edges, measures the cycles between edges and compares each interval against an expected half-period.
- Reports lock, sticky error, error count, toggle count and last measured interval.
- Sits next to the toggle source as a self-checking sink in the top level and testbenches.

Parameters:
- CNT_W, 8: interval counter width.
- EXP_HALF, 1: expected CK cycles between edges (1 for `flipflop_not`).
- TOL, 0: allowed deviation in cycles. Must satisfy TOL < EXP_HALF and EXP_HALF+TOL < 2^CNT_W-1.
- LOCK_N, 4: consecutive good intervals needed to assert LOCKED.
- TOG_W, 16: toggle counter width.

Ports:
- CK  in  1  clock; all logic on rising edge.
- RB  in  1  reset; asynchronous, active-high.
- EN  in  1  enable; synchronous.
- CLR  in  1  synchronous clear of ERR, ERR_CNT, TOG_CNT.
- Q_IN  in  1  monitored signal, same CK domain; no synchronizer.
- LOCKED  out  1  interval tracking locked.
- ERR  out  1  sticky error flag.
- ERR_PULSE  out  1  one-cycle pulse per error in LOCK.
- ERR_CNT  out  8  error count, saturates at 255.
- TOG_CNT  out  TOG_W  edges seen in ACQUIRE/LOCK; wraps.
- LAST_HALF  out  CNT_W  most recent measured interval.

Behaviour:
- Reset (RB=1, asynchronous): state IDLE. All outputs, q_d, cnt and good_cnt = 0.
- Edge detect: q_d <= Q_IN every cycle; edge = Q_IN ^ q_d (combinational).
- cnt = CK cycles elapsed since the last edge.
  - Edge cycle: measured interval = cnt; cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at 2^CNT_W-1.
- Good interval: EXP_HALF-TOL <= cnt <= EXP_HALF+TOL at an edge.
- Bad interval:
  - early: edge with cnt < EXP_HALF-TOL;
  - timeout: non-edge cycle with cnt == EXP_HALF+TOL. Fires once, then is suppressed until the next edge.
- States and transitions:
  - Any state: EN=0 -> IDLE next cycle. Clears good_cnt and LOCKED; counters hold. EN=0 wins over a same-cycle edge (no count).
  - IDLE: EN=1 -> ARM.
  - ARM: first edge -> ACQUIRE with cnt=1. That edge is not measured and not counted.
  - ACQUIRE:
    - good edge: good_cnt++; when it reaches LOCK_N -> LOCK, with LOCKED=1 the following cycle;
    - bad edge or timeout: good_cnt=0, stay in ACQUIRE, no error reported.
  - LOCK:
    - good edge: stay;
    - bad edge or timeout: ERR_PULSE=1 for one cycle, ERR<=1, ERR_CNT++ (saturating), LOCKED<=0, good_cnt=0 -> ACQUIRE.
- TOG_CNT increments on every edge in ACQUIRE or LOCK.
- LAST_HALF loads cnt on every edge in ACQUIRE or LOCK.
- All outputs are registered; observed response is one cycle after the causing edge.
- CLR:
  - clears ERR, ERR_CNT and TOG_CNT, taking priority over same-cycle increments;
  - does not affect state, LOCKED, LAST_HALF or ERR_PULSE;
  - with CLR and an error in the same cycle: ERR_PULSE=1, ERR=0, ERR_CNT=0.
- Reset mid-operation clears all state immediately, with no clock edge required.

Decomposition:
- Package/include toggle_chk_pkg: state encodings (IDLE, ARM, ACQUIRE, LOCK as 2-bit localparams), ERR_CNT width 8, saturation constants.
- One sub-module, edge_interval_counter. It holds q_d, the edge detect, the saturating cnt and the good/early/timeout classification, and outputs edge, good, bad and interval.
- The FSM, statistics and CLR logic stay in toggle_checker.

Test Plan:
- Reset: pulse RB=1 for 5 time units before any CK edge -> LOCKED=ERR=ERR_PULSE=0, ERR_CNT=TOG_CNT=LAST_HALF=0. Asynchronous assert mid-LOCK -> all outputs 0 immediately.
- Lock on `flipflop_not` Q (defaults, Q toggles every cycle), EN=1 -> ARM edge, then 4 good intervals -> LOCKED=1; LAST_HALF=1; TOG_CNT +1 per cycle after ARM.
- Stuck input: while LOCKED, hold Q_IN constant 3 cycles -> timeout at cnt=1 with no edge -> ERR_PULSE one cycle, ERR=1, ERR_CNT=1, LOCKED=0; resume toggling -> LOCKED=1 after 4 good edges; ERR stays 1.
- Tolerance (EXP_HALF=3, TOL=1): intervals 2,3,4 -> no error, LOCKED holds; interval 1 -> early error; no edge at cnt=4 -> timeout error; ERR_CNT=2.
- CLR collision: CLR=1 on the same cycle as a LOCK error -> ERR_PULSE=1, ERR=0, ERR_CNT=0, TOG_CNT=0. 256 errors without CLR -> ERR_CNT=255 (saturates).
- Enable: EN=0 same cycle as an edge in LOCK -> IDLE, LOCKED=0, TOG_CNT unchanged. EN=1 -> ARM, first edge not counted.
